seven_seg_scan_controller: RTL
==============================

Name: seven_seg_scan_controller

Overview:
- Sequences a four-digit multiplexed seven-segment display bank.
- Accepts 16-bit display values through a valid/ready handshake and double-buffers them, committing only at frame boundaries so there is no tearing.
- Scans digits 0..3 with programmable brightness (PWM duty) and optional leading-zero blanking.
- Outputs a digit-select vector and a nibble plus decimal point, which feed the shared hex-to-segment decoder.

Parameters:
- PRESCALE, 4, clk cycles per PWM tick; legal range 1..65535.
- TICKS_PER_DIGIT, 16, PWM ticks per digit slot; fixed power of two, matches the 4-bit brightness.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- value  input  16  display value; digit i shows value[4i+3:4i]
- dp_mask  input  4  decimal point per digit, sampled together with value
- value_valid  input  1  producer offers value/dp_mask
- value_ready  output  1  controller can accept into pending buffer
- brightness  input  4  on-ticks per digit slot; 0 = dark, 15 = max
- lz_blank  input  1  enable leading-zero blanking
- select  output  4  active-low digit enable, one-hot-low or 4'b1111
- data  output  4  nibble for the active digit
- dp  output  1  decimal point for the active digit, active-high
- frame_start  output  1  one-cycle pulse when digit 0 slot begins

Behaviour:
Reset (async assert, sync release):
- select=4'b1111, data=0, dp=0, frame_start=0, value_ready=1.
- Active and pending buffers cleared; pending_full=0.
- Digit index=0; prescaler and tick counters=0.

Prescaler:
- Counts 0..PRESCALE-1; tick asserts for 1 cycle at PRESCALE-1, then wraps.
- PRESCALE=1 gives a tick every cycle.

Slot counter:
- 4 bits, increments on tick.
- On wrap 15->0, the digit index advances 0->1->2->3->0.

State machine (typedef scan_state_t): SCAN0, SCAN1, SCAN2, SCAN3; no other states.
- Transition occurs on tick while slot==15.
- SCAN3->SCAN0 is the frame boundary.

Handshake:
- Transfer occurs when value_valid && value_ready on a rising edge.
- Accepted data goes to the pending buffer and sets pending_full.
- value_ready = !pending_full (combinational from a registered flag).
- At the frame boundary with pending_full: active<=pending and pending_full<=0 in the same edge.
- If a transfer and a frame boundary coincide while pending_full=1: value_ready is 0, so no transfer occurs; commit proceeds.
- If a transfer and a frame boundary coincide while pending_full=0: the new value goes to pending and commits at the next boundary.

Outputs (all registered, one cycle after internal state):
- lit = (slot < brightness) && !blank(digit).
- select = lit ? ~(4'b0001<<digit) : 4'b1111.
- data = active nibble of digit, regardless of lit.
- dp = dp_mask_active[digit] && lit.
- frame_start = 1 for exactly one cycle on entry to SCAN0 (registered with the select update); not asserted out of reset.

Leading-zero blanking:
- blank(i) = lz_blank && i!=0 && all active nibbles j>=i are zero.
- Digit 0 is never blanked.
- The blanking decision uses the committed active value only.
- A digit with its dp bit set is not blanked.

Brightness:
- Sampled continuously; a change takes effect at the next slot compare.
- No glitch guarantee is required within a slot.

Reset mid-frame: all state returns to reset values immediately; any pending value is discarded.

Decomposition:
- Package seven_seg_pkg holds scan_state_t, DIGITS=4, and SLOT_W=4.
- One sub-module: seven_seg_prescaler, with parameter PRESCALE, outputs tick.
- The hex-to-segment decode stays outside this block.

Test Plan:
- Reset, brightness=15, no load, PRESCALE=1 -> select cycles 1110,1101,1011,0111 every 16 cycles; data=0; frame_start period 64 cycles.
- Load 16'h1234 with dp_mask=4'b0100 mid-frame -> value_ready drops next cycle; digits keep showing 0 until the next frame_start; then digit3 shows 1, digit0 shows 4, dp only on digit2; value_ready returns 1.
- brightness=4, PRESCALE=3 -> each digit low for 12 cycles, then select=1111 for 36 cycles per slot; brightness=0 -> select stays 1111 while data still scans.
- lz_blank=1, value=16'h0050 -> digits 3 and 2 never selected; digits 1 and 0 lit (0 shown on digit0). value=16'h0000 -> only digit0 lit.
- Back-to-back valid: two loads within one frame -> second held off by value_ready=0 until the boundary; second value displayed one frame after the first.
- Assert reset_n=0 during SCAN2 with pending_full=1 -> select=1111 and value_ready=1 asynchronously; after release, scan restarts at digit0 showing 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package seven_seg_pkg;

    localparam int DIGITS = 4;
    localparam int SLOT_W = 4;

    typedef enum logic [1:0] {
        SCAN0 = 2'd0,
        SCAN1 = 2'd1,
        SCAN2 = 2'd2,
        SCAN3 = 2'd3
    } scan_state_t;

    // True when every nibble at position idx and above is zero.
    function automatic logic upper_zero(input logic [15:0] v, input logic [1:0] idx);
        logic z;
        z = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if ((j >= int'(idx)) && (v[4*j +: 4] != 4'h0)) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// Divides clk down to a single-cycle PWM tick every PRESCALE cycles.
module seven_seg_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Multiplexed four-digit scan controller: double-buffered value, PWM brightness,
// leading-zero blanking, registered digit select / nibble / decimal point outputs.
module seven_seg_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int PRESCALE        = 4,
    parameter int TICKS_PER_DIGIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic [3:0]  brightness,
    input  logic        lz_blank,
    output logic [3:0]  select,
    output logic [3:0]  data,
    output logic        dp,
    output logic        frame_start
);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(TICKS_PER_DIGIT - 1);

    logic tick;

    scan_state_t state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [15:0] active_q, active_d;
    logic [3:0]  active_dp_q, active_dp_d;
    logic [15:0] pend_q, pend_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic        pend_full_q, pend_full_d;
    logic        boundary_q, boundary_d;
    logic [3:0]  select_q, select_d;
    logic [3:0]  data_q, data_d;
    logic        dp_q, dp_d;
    logic        frame_start_q, frame_start_d;

    logic        slot_end;
    logic        frame_end;
    logic        xfer;
    logic [1:0]  digit;
    logic        blank;
    logic        lit;

    seven_seg_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

    always_comb begin
        slot_end  = tick && (slot_q == SLOT_LAST);
        frame_end = slot_end && (state_q == SCAN3);
        state_d   = state_q;
        if (slot_end) begin
            case (state_q)
                SCAN0:   state_d = SCAN1;
                SCAN1:   state_d = SCAN2;
                SCAN2:   state_d = SCAN3;
                SCAN3:   state_d = SCAN0;
                default: state_d = SCAN0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SCAN0;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending buffer accepts only when empty; it drains into active at the frame boundary.
    always_comb begin
        value_ready = !pend_full_q;
        xfer        = value_valid && value_ready;
        slot_d      = tick ? slot_q + SLOT_W'(1) : slot_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        if (frame_end && pend_full_q) begin
            active_d    = pend_q;
            active_dp_d = pend_dp_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_d      = value;
            pend_dp_d   = dp_mask;
            pend_full_d = 1'b1;
        end
        boundary_d = frame_end;
    end

    // Output stage: registered one cycle behind slot/state so frame_start lines up with digit 0.
    always_comb begin
        digit         = state_q;
        blank         = lz_blank && (digit != 2'd0) && upper_zero(active_q, digit)
                        && !active_dp_q[digit];
        lit           = (slot_q < brightness) && !blank;
        select_d      = lit ? ~(4'b0001 << digit) : 4'b1111;
        data_d        = active_q[{digit, 2'b00} +: 4];
        dp_d          = active_dp_q[digit] && lit;
        frame_start_d = boundary_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q        <= '0;
            active_q      <= '0;
            active_dp_q   <= '0;
            pend_q        <= '0;
            pend_dp_q     <= '0;
            pend_full_q   <= 1'b0;
            boundary_q    <= 1'b0;
            select_q      <= 4'b1111;
            data_q        <= '0;
            dp_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            active_q      <= active_d;
            active_dp_q   <= active_dp_d;
            pend_q        <= pend_d;
            pend_dp_q     <= pend_dp_d;
            pend_full_q   <= pend_full_d;
            boundary_q    <= boundary_d;
            select_q      <= select_d;
            data_q        <= data_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign select      = select_q;
    assign data        = data_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule
